// File: rtl/pio_in_debounce.sv
// Two-flop synchroniser plus per-bit debounce in front of the PIO input port.
// Optional glitch statistics are built when DEBOUNCE_GLITCH_CNT_EN is defined.
module pio_in_debounce #(
    parameter int               WIDTH          = 32,
    parameter int               TICK_DIV       = 50,
    parameter int               DEBOUNCE_TICKS = 1000,
    parameter int               CNT_W          = 16,
    parameter logic [WIDTH-1:0] RESET_VAL      = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] raw_in,
    input  logic             en,
    output logic [WIDTH-1:0] db_out,
    output logic [WIDTH-1:0] changed
`ifdef DEBOUNCE_GLITCH_CNT_EN
    ,
    output logic [15:0]      glitch_cnt,
    input  logic             glitch_clr
`endif
);

    localparam int               PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]    PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0]    PRESC_ONE  = PW'(1);
    localparam logic [PW-1:0]    PRESC_ZERO = PW'(0);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DEBOUNCE_TICKS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);

    logic [WIDTH-1:0] s1_q;
    logic [WIDTH-1:0] s2_q;
    logic [PW-1:0]    presc_q;
    logic [PW-1:0]    presc_d;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];
    logic [WIDTH-1:0] db_q;
    logic [WIDTH-1:0] db_d;
    logic [WIDTH-1:0] chg_q;
    logic [WIDTH-1:0] chg_d;
    logic             tick_s;
    logic             glitch_any_s;

    // Shared sample-tick prescaler, parked at zero while disabled
    always_comb begin
        tick_s  = en && (presc_q == PRESC_LAST);
        presc_d = presc_q;
        if (!en) begin
            presc_d = PRESC_ZERO;
        end else if (tick_s) begin
            presc_d = PRESC_ZERO;
        end else begin
            presc_d = presc_q + PRESC_ONE;
        end
    end

    // Per-bit qualification: a level is accepted only after DEBOUNCE_TICKS
    // consecutive mismatching ticks; any return to the old level restarts it
    always_comb begin
        db_d         = db_q;
        chg_d        = {WIDTH{1'b0}};
        glitch_any_s = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (!en) begin
                cnt_d[i] = CNT_ZERO;
            end else if (s2_q[i] == db_q[i]) begin
                cnt_d[i] = CNT_ZERO;
                if (cnt_q[i] != CNT_ZERO) begin
                    glitch_any_s = 1'b1;
                end else begin
                    glitch_any_s = glitch_any_s;
                end
            end else if (tick_s && (cnt_q[i] == CNT_LAST)) begin
                db_d[i]  = s2_q[i];
                cnt_d[i] = CNT_ZERO;
                chg_d[i] = 1'b1;
            end else if (tick_s) begin
                cnt_d[i] = cnt_q[i] + CNT_ONE;
            end else begin
                cnt_d[i] = cnt_q[i];
            end
        end
    end

    // State registers: synchroniser, prescaler, counters, outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q    <= RESET_VAL;
            s2_q    <= RESET_VAL;
            presc_q <= PRESC_ZERO;
            db_q    <= RESET_VAL;
            chg_q   <= {WIDTH{1'b0}};
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= CNT_ZERO;
            end
        end else begin
            s1_q    <= raw_in;
            s2_q    <= s1_q;
            presc_q <= presc_d;
            db_q    <= db_d;
            chg_q   <= chg_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign db_out  = db_q;
    assign changed = chg_q;

`ifdef DEBOUNCE_GLITCH_CNT_EN
    logic [15:0] glitch_q;
    logic [15:0] glitch_d;

    // Saturating count of cycles that rejected at least one partial qualification
    always_comb begin
        glitch_d = glitch_q;
        if (glitch_clr) begin
            glitch_d = 16'h0000;
        end else if (glitch_any_s && (glitch_q != 16'hFFFF)) begin
            glitch_d = glitch_q + 16'h0001;
        end else begin
            glitch_d = glitch_q;
        end
    end

    // Glitch counter register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            glitch_q <= 16'h0000;
        end else begin
            glitch_q <= glitch_d;
        end
    end

    assign glitch_cnt = glitch_q;
`else
    logic unused_glitch_s;
    assign unused_glitch_s = glitch_any_s;
`endif

endmodule

// File: tb/tb_pio_in_debounce.sv
// Directed bench for pio_in_debounce (WIDTH=8, TICK_DIV=4, DEBOUNCE_TICKS=3).
// Glitch-counter checks compile in when DEBOUNCE_GLITCH_CNT_EN is defined.
module tb_pio_in_debounce;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] raw_in;
    logic       en;
    logic [7:0] db_out;
    logic [7:0] changed;
`ifdef DEBOUNCE_GLITCH_CNT_EN
    logic [15:0] glitch_cnt;
    logic        glitch_clr;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pio_in_debounce #(
        .WIDTH(8), .TICK_DIV(4), .DEBOUNCE_TICKS(3), .CNT_W(4), .RESET_VAL(8'h00)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .raw_in(raw_in),
        .en(en),
        .db_out(db_out),
        .changed(changed)
`ifdef DEBOUNCE_GLITCH_CNT_EN
        ,
        .glitch_cnt(glitch_cnt),
        .glitch_clr(glitch_clr)
`endif
    );

    typedef struct {
        logic [7:0] raw;
        logic       en;
        int         cyc;
        logic [7:0] exp_db;
        logic [7:0] exp_chg;
        int         exp_pulses;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d..%0d", name, act, lo, hi);
        end
    endtask

    // One clock; inputs are driven and outputs sampled 1 ns after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Steps until db_out[bit] becomes 1 (bounded); returns step count, 0 on timeout
    task automatic wait_bit(input int b, input int limit, output int k, output int pulses, output logic [7:0] other_mv);
        logic [7:0] start;
        start    = db_out;
        k        = 0;
        pulses   = 0;
        other_mv = 8'h00;
        for (int n = 1; n <= limit; n++) begin
            step();
            if (changed != 8'h00) pulses++;
            other_mv = other_mv | ((db_out ^ start) & ~(8'h01 << b));
            if (db_out[b] && k == 0) k = n;
        end
    endtask

`ifdef DEBOUNCE_GLITCH_CNT_EN
    // One glitch on bit 3: four cycles high (always spans one tick) then four low
    task automatic glitch_period();
        raw_in[3] = 1'b1;
        repeat (4) step();
        raw_in[3] = 1'b0;
        repeat (4) step();
    endtask
`endif

    initial begin
        int         k;
        int         pulses;
        logic [7:0] other_mv;
        logic       bad;
        logic [7:0] chg_or;

        vecs[0] = '{8'h00, 1'b1, 16, 8'h00, 8'h07, 1};
        vecs[1] = '{8'hA5, 1'b1, 16, 8'hA5, 8'hA5, 1};
        vecs[2] = '{8'h5A, 1'b1,  8, 8'hA5, 8'h00, 0};
        vecs[3] = '{8'h5A, 1'b1,  8, 8'h5A, 8'hFF, 1};
        vecs[4] = '{8'hFF, 1'b0, 20, 8'h5A, 8'h00, 0};
        vecs[5] = '{8'hFF, 1'b1, 10, 8'h5A, 8'h00, 0};
        vecs[6] = '{8'hFF, 1'b1,  6, 8'hFF, 8'hA5, 1};
        vecs[7] = '{8'h00, 1'b1,  8, 8'hFF, 8'h00, 0};
        vecs[8] = '{8'hFF, 1'b1, 16, 8'hFF, 8'h00, 0};

        reset_n = 1'b1;
        raw_in  = 8'hFF;
        en      = 1'b0;
`ifdef DEBOUNCE_GLITCH_CNT_EN
        glitch_clr = 1'b0;
`endif
        #2 reset_n = 1'b0;

        // Reset held 3 cycles with all inputs high
        for (int n = 0; n < 3; n++) begin
            step();
            check("reset_db", db_out, 8'h00);
            check("reset_chg", changed, 8'h00);
        end
`ifdef DEBOUNCE_GLITCH_CNT_EN
        check("reset_glitch", glitch_cnt, 16'h0000);
`endif
        raw_in  = 8'h00;
        reset_n = 1'b1;
        en      = 1'b1;
        repeat (4) step();

        // Clean step on bit 0
        raw_in[0] = 1'b1;
        wait_bit(0, 20, k, pulses, other_mv);
        check_range("step_latency", k, 11, 14);
        check("step_pulses", pulses, 1);
        check("step_others", other_mv, 8'h00);

        // Bounce on bit 1: 3-cycle toggles never qualify
        bad = 1'b0;
        for (int n = 0; n < 40; n++) begin
            if (n % 3 == 0) raw_in[1] = ~raw_in[1];
            step();
            if (db_out[1] !== 1'b0) bad = 1'b1;
        end
        check("bounce_hold", bad, 1'b0);
        raw_in[1] = 1'b1;
        wait_bit(1, 20, k, pulses, other_mv);
        check_range("bounce_settle", k, 1, 14);
`ifdef DEBOUNCE_GLITCH_CNT_EN
        check("bounce_glitch_nz", glitch_cnt != 16'h0000, 1'b1);
`endif

        // Enable dropped mid-qualification on bit 2
        raw_in[2] = 1'b1;
        repeat (10) step();
        en  = 1'b0;
        bad = 1'b0;
        for (int n = 0; n < 20; n++) begin
            step();
            if (db_out[2] !== 1'b0 || changed !== 8'h00) bad = 1'b1;
        end
        check("en_low_hold", bad, 1'b0);
        en = 1'b1;
        wait_bit(2, 20, k, pulses, other_mv);
        check_range("en_relatency", k, 11, 14);
        check("en_pulses", pulses, 1);

`ifdef DEBOUNCE_GLITCH_CNT_EN
        // Saturation and clear priority
        dut.glitch_q = 16'hFFFD;
        for (int n = 0; n < 6; n++) glitch_period();
        check("glitch_sat", glitch_cnt, 16'hFFFF);
        glitch_clr = 1'b1;
        glitch_period();
        glitch_clr = 1'b0;
        step();
        check("glitch_clr", glitch_cnt, 16'h0000);
        glitch_period();
        check("glitch_after_clr", glitch_cnt, 16'h0001);
`endif
        check("pre_table_db", db_out, 8'h07);

        // Table-driven vectors
        for (int v = 0; v < 9; v++) begin
            raw_in = vecs[v].raw;
            en     = vecs[v].en;
            chg_or = 8'h00;
            pulses = 0;
            for (int n = 0; n < vecs[v].cyc; n++) begin
                step();
                chg_or = chg_or | changed;
                if (changed != 8'h00) pulses++;
            end
            check($sformatf("vec%0d_db", v), db_out, vecs[v].exp_db);
            check($sformatf("vec%0d_chg", v), chg_or, vecs[v].exp_chg);
            check($sformatf("vec%0d_pulses", v), pulses, vecs[v].exp_pulses);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
